// File: rtl/i2c_calc_target.sv
// I2C target front-end for a byte calculator.
// A two-byte write at DEV_ADDR loads operand A then operand B and emits a
// one-cycle op_valid; reads at DEV_ADDR return the calculator result byte,
// reloaded for every byte the master ACKs.
//
// Downstream contract: op_valid is a single-cycle pulse with no ready/back-
// pressure. op_a/op_b are registered and only change at their own write loads,
// so they are stable in the op_valid cycle and remain stable until the next
// load.
module i2c_calc_target #(
    parameter logic [6:0] DEV_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_valid,
    input  logic [7:0] result,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6
    } state_t;

    // Synchronized bus lines and their one-cycle-delayed copies.
    logic scl_meta, scl_sync, scl_prev;
    logic sda_meta, sda_sync, sda_prev;

    // Registered FSM state and datapath.
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [1:0] byte_idx;
    logic       byte_full;  // eight bits shifted in, waiting for the SCL fall
    logic       rw_bit;
    logic       rd_acked;   // master ACKed a read byte, reload on next fall

    // Next-state values.
    state_t     state_nxt;
    logic [2:0] bit_cnt_nxt;
    logic [7:0] shift_nxt;
    logic [1:0] byte_idx_nxt;
    logic       byte_full_nxt;
    logic       rw_bit_nxt;
    logic       rd_acked_nxt;
    logic       sda_oe_nxt;
    logic [7:0] op_a_nxt;
    logic [7:0] op_b_nxt;
    logic       op_valid_nxt;

    // Bus events derived only from synchronized samples.
    logic start_det, stop_det, scl_rise, scl_fall;

    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;

    assign busy = (state != IDLE);

    // Two-flop synchronizers plus delayed copies; reset to an idle (high) bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            byte_idx  <= 2'd0;
            byte_full <= 1'b0;
            rw_bit    <= 1'b0;
            rd_acked  <= 1'b0;
            sda_oe    <= 1'b0;
            op_a      <= 8'd0;
            op_b      <= 8'd0;
            op_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            byte_idx  <= byte_idx_nxt;
            byte_full <= byte_full_nxt;
            rw_bit    <= rw_bit_nxt;
            rd_acked  <= rd_acked_nxt;
            sda_oe    <= sda_oe_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            op_valid  <= op_valid_nxt;
        end
    end

    // Next-state logic: START/STOP first, then SCL edge handling per state.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        byte_idx_nxt  = byte_idx;
        byte_full_nxt = byte_full;
        rw_bit_nxt    = rw_bit;
        rd_acked_nxt  = rd_acked;
        sda_oe_nxt    = sda_oe;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        op_valid_nxt  = 1'b0;

        if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd0;
            byte_idx_nxt  = 2'd0;
            byte_full_nxt = 1'b0;
            rd_acked_nxt  = 1'b0;
            sda_oe_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift_reg[6:0], sda_sync};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_full_nxt = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        if (shift_reg[7:1] == DEV_ADDR) begin
                            rw_bit_nxt = shift_reg[0];
                            sda_oe_nxt = 1'b1;
                            state_nxt  = ADDR_ACK;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = IDLE;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = 3'd0;
                        if (rw_bit) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            shift_nxt  = result;
                            sda_oe_nxt = ~result[7];
                            state_nxt  = READ;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift_reg[6:0], sda_sync};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_full_nxt = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        state_nxt     = WRITE_ACK;
                        case (byte_idx)
                            2'd0: begin
                                op_a_nxt     = shift_reg;
                                sda_oe_nxt   = 1'b1;
                                byte_idx_nxt = 2'd1;
                            end
                            2'd1: begin
                                op_b_nxt     = shift_reg;
                                op_valid_nxt = 1'b1;
                                sda_oe_nxt   = 1'b1;
                                byte_idx_nxt = 2'd2;
                            end
                            default: begin
                                // Extra bytes are dropped and NACKed.
                                sda_oe_nxt = 1'b0;
                            end
                        endcase
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = WRITE;
                    end
                end

                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_nxt   = 1'b0;
                            bit_cnt_nxt  = 3'd0;
                            rd_acked_nxt = 1'b0;
                            state_nxt    = READ_ACK;
                        end else begin
                            shift_nxt   = {shift_reg[6:0], 1'b0};
                            sda_oe_nxt  = ~shift_reg[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync) state_nxt = IDLE;
                        else          rd_acked_nxt = 1'b1;
                    end else if (scl_fall && rd_acked) begin
                        rd_acked_nxt = 1'b0;
                        shift_nxt    = result;
                        sda_oe_nxt   = ~result[7];
                        bit_cnt_nxt  = 3'd0;
                        state_nxt    = READ;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_calc_target.sv
// Self-checking bench for i2c_calc_target: directed bus scenarios followed by
// randomized transactions against a transaction-level model of the target.
module tb_i2c_calc_target;

    localparam int         Q   = 50;     // quarter SCL period in ns (SCL = 20 clk)
    localparam logic [6:0] DEV = 7'h2A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] result = 8'h00;
    logic       sda_oe, op_valid, busy;
    logic [7:0] op_a, op_b;
    logic       sda_line;

    // Open-drain bus: the line is low if either side pulls it down.
    assign sda_line = sda_m & ~sda_oe;

    i2c_calc_target #(.DEV_ADDR(DEV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .result   (result),
        .busy     (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         valid_cnt  = 0;
    int         long_pulse = 0;
    int         oe_cnt     = 0;
    logic       prev_valid = 1'b0;

    // Event monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (op_valid) valid_cnt++;
        if (op_valid && prev_valid) long_pulse++;
        prev_valid = op_valid;
        if (sda_oe) oe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- I2C master driver ----------------
    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q; sda_m = 1'b0;
        #Q; scl_m = 1'b1;
        #Q; sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b, output logic seen);
        #Q; sda_m = b;
        #Q; scl_m = 1'b1;
        #Q; seen = sda_line;
        #Q; scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    // next_res is applied before the ACK bit, so an ACKed byte reloads it.
    task automatic read_byte(input logic master_ack, input logic [7:0] next_res,
                             output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        result = next_res;
        send_bit(~master_ack, s);
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic [7:0] d, nr;
        logic [6:0] a;
        logic       rw, match, got_oe;
        int         n, vbase, exp_valid;
        logic [7:0] m_a, m_b;

        // Reset state
        rst_n = 1'b0;
        idle_clks(3);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_op_a", op_a, 0);
        check_eq("rst_op_b", op_b, 0);
        check_eq("rst_op_valid", op_valid, 0);
        rst_n = 1'b1;
        idle_clks(5);
        m_a = 8'h00; m_b = 8'h00; exp_valid = 0;

        // Two-byte write loads both operands, one pulse after byte 2
        i2c_start();
        write_byte(8'h54, ack); check_eq("wr_addr_ack", ack, 1);
        write_byte(8'h12, ack); check_eq("wr_b0_ack", ack, 1);
        check_eq("wr_no_valid_b0", valid_cnt, exp_valid);
        write_byte(8'h34, ack); check_eq("wr_b1_ack", ack, 1);
        exp_valid++;
        check_eq("wr_valid_b1", valid_cnt, exp_valid);
        i2c_stop();
        idle_clks(4);
        m_a = 8'h12; m_b = 8'h34;
        check_eq("wr_op_a", op_a, m_a);
        check_eq("wr_op_b", op_b, m_b);
        check_eq("wr_busy_after_stop", busy, 0);

        // Wrong address is ignored entirely
        oe_cnt = 0;
        i2c_start();
        write_byte(8'h56, ack); check_eq("bad_addr_ack", ack, 0);
        idle_clks(2);
        check_eq("bad_addr_busy", busy, 0);
        write_byte(8'h11, ack); check_eq("bad_data_ack", ack, 0);
        i2c_stop();
        idle_clks(4);
        check_eq("bad_oe_seen", oe_cnt, 0);
        check_eq("bad_op_a", op_a, m_a);
        check_eq("bad_op_b", op_b, m_b);
        check_eq("bad_valid", valid_cnt, exp_valid);

        // Single-byte read with NACK
        result = 8'hA5;
        i2c_start();
        write_byte(8'h55, ack); check_eq("rd_addr_ack", ack, 1);
        read_byte(1'b0, 8'hA5, d);
        check_eq("rd_data", d, 8'hA5);
        idle_clks(4);
        check_eq("rd_idle_after_nack", busy, 0);
        i2c_stop();

        // Third write byte overflows and is NACKed
        i2c_start();
        write_byte(8'h54, ack); check_eq("ovf_addr_ack", ack, 1);
        write_byte(8'h01, ack); check_eq("ovf_b0_ack", ack, 1);
        write_byte(8'h02, ack); check_eq("ovf_b1_ack", ack, 1);
        write_byte(8'h99, ack); check_eq("ovf_b2_ack", ack, 0);
        i2c_stop();
        idle_clks(4);
        exp_valid++; m_a = 8'h01; m_b = 8'h02;
        check_eq("ovf_op_a", op_a, m_a);
        check_eq("ovf_op_b", op_b, m_b);
        check_eq("ovf_valid", valid_cnt, exp_valid);

        // Single-byte write, repeated START, read
        i2c_start();
        write_byte(8'h54, ack); check_eq("rs_addr_ack", ack, 1);
        write_byte(8'h07, ack); check_eq("rs_b0_ack", ack, 1);
        result = 8'h3C;
        i2c_start();
        write_byte(8'h55, ack); check_eq("rs_rd_addr_ack", ack, 1);
        read_byte(1'b0, 8'h3C, d);
        check_eq("rs_rd_data", d, 8'h3C);
        i2c_stop();
        idle_clks(4);
        m_a = 8'h07;
        check_eq("rs_op_a", op_a, m_a);
        check_eq("rs_op_b", op_b, m_b);
        check_eq("rs_valid", valid_cnt, exp_valid);

        // Randomized transactions against the transaction-level model
        for (int t = 0; t < 20; t++) begin
            a     = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV;
            match = (a == DEV);
            rw    = 1'($urandom_range(0, 1));
            oe_cnt = 0;
            vbase  = valid_cnt;
            if (rw) result = 8'($urandom);
            i2c_start();
            write_byte({a, rw}, ack);
            check_eq("rnd_addr_ack", ack, match);
            if (!rw) begin
                n = $urandom_range(0, 4);
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    write_byte(d, ack);
                    check_eq("rnd_wr_ack", ack, match && (k < 2));
                    if (match && k == 0) m_a = d;
                    if (match && k == 1) m_b = d;
                end
                if (match && n >= 2) exp_valid++;
            end else begin
                n = $urandom_range(1, 3);
                exp_q.push_back(match ? result : 8'hFF);
                for (int k = 0; k < n; k++) begin
                    nr = 8'($urandom);
                    read_byte(k < n - 1, nr, d);
                    check_eq("rnd_rd_data", d, exp_q.pop_front());
                    if (k < n - 1) exp_q.push_back(match ? nr : 8'hFF);
                end
            end
            i2c_stop();
            idle_clks(4);
            check_eq("rnd_busy", busy, 0);
            check_eq("rnd_op_a", op_a, m_a);
            check_eq("rnd_op_b", op_b, m_b);
            check_eq("rnd_valid", valid_cnt, exp_valid);
            if (!match) check_eq("rnd_bad_oe", oe_cnt, 0);
        end
        check_eq("valid_one_cycle", long_pulse, 0);

        // Reset while driving a read bit low
        result = 8'h00;
        i2c_start();
        write_byte(8'h55, ack); check_eq("rr_addr_ack", ack, 1);
        got_oe = 1'b0;
        for (int i = 0; i < 20 && !got_oe; i++) begin
            @(negedge clk);
            got_oe = sda_oe;
        end
        check_eq("rr_oe_before_rst", got_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rr_async_sda_oe", sda_oe, 0);
        check_eq("rr_async_busy", busy, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        idle_clks(3);
        rst_n = 1'b1;
        idle_clks(3);
        check_eq("rr_op_a", op_a, 0);
        check_eq("rr_op_b", op_b, 0);

        // Without a new START the target stays off the bus
        oe_cnt = 0;
        vbase  = valid_cnt;
        scl_m = 1'b0;
        write_byte(8'h54, ack); check_eq("nostart_addr_ack", ack, 0);
        write_byte(8'h12, ack);
        write_byte(8'h34, ack);
        i2c_stop();
        idle_clks(4);
        check_eq("nostart_oe", oe_cnt, 0);
        check_eq("nostart_busy", busy, 0);
        check_eq("nostart_valid", valid_cnt, vbase);
        check_eq("nostart_op_a", op_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_calc_target.md
I2C_CALC_TARGET -- requirements
Module: i2c_calc_target

Interface
REQ-001 SHALL provide parameter DEV_ADDR, default 7'h2A, 7-bit I2C target address.
REQ-002 SHALL provide port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port scl_in  input  1  raw I2C SCL, asynchronous to clk.
REQ-005 SHALL provide port sda_in  input  1  raw I2C SDA, asynchronous to clk.
REQ-006 SHALL provide port sda_oe  output  1  open-drain SDA pull-down; 1 = drive low, 0 = release.
REQ-007 SHALL provide port op_a  output  8  operand A for downstream calculator.
REQ-008 SHALL provide port op_b  output  8  operand B for downstream calculator.
REQ-009 SHALL provide port op_valid  output  1  one-cycle pulse: op_a/op_b form a new operand pair.
REQ-010 SHALL provide port result  input  8  calculator result byte returned on I2C reads.
REQ-011 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-FF synchronizers; all detection uses synced values and their one-cycle-delayed copies; fclk >= 10x SCL rate.
REQ-013 SHALL detect START as synced SDA 1->0 while synced SCL high in both cycles; STOP as SDA 0->1 while SCL high.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
REQ-015 SHALL on START from any state (incl. repeated START) enter ADDR, clear bit counter, clear byte index, release sda_oe.
REQ-016 SHALL on STOP from any state enter IDLE and release sda_oe; START/STOP take priority over SCL edge processing in the same cycle.
REQ-017 SHALL sample SDA on each SCL rising edge in ADDR/WRITE, shifting MSB first; 3-bit counter wraps 7->0.
REQ-018 SHALL, on the SCL falling edge after the 8th address bit: if byte[7:1]==DEV_ADDR enter ADDR_ACK with sda_oe=1, else enter IDLE with sda_oe=0 (ignore bus until next START).
REQ-019 SHALL, on the SCL falling edge ending ADDR_ACK, release sda_oe and enter WRITE if R/W=0; if R/W=1 latch result into shift register, enter READ, and set sda_oe = ~result[7] in that same cycle.
REQ-020 SHALL, on the SCL falling edge after the 8th WRITE bit: byte index 0 -> load op_a, ACK; index 1 -> load op_b, pulse op_valid for exactly one clk, ACK; index >=2 -> discard, no ACK (sda_oe stays 0); enter WRITE_ACK; index saturates at 2.
REQ-021 SHALL release sda_oe and return to WRITE on the SCL falling edge ending WRITE_ACK.
REQ-022 SHALL in READ update sda_oe = ~next bit on each SCL falling edge, MSB first; after the 8th bit's falling edge release sda_oe and enter READ_ACK.
REQ-023 SHALL in READ_ACK sample SDA on SCL rising edge: 0 (ACK) -> relatch result, drive its MSB on next falling edge, return to READ; 1 (NACK) -> IDLE.
REQ-024 SHALL change sda_oe only on detected SCL falling edge, START, STOP, or reset; sda_oe SHALL be 0 in IDLE.
REQ-025 SHALL hold op_a/op_b stable except at the loads of REQ-020; op_valid never asserts for a single-byte write.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE, sda_oe=0, op_a=0, op_b=0, op_valid=0, busy=0, counters and shift registers 0, synchronizers to 1 (idle bus).
REQ-027 SHALL abandon any transaction on reset with no further ACK or op_valid; operation resumes only from the next START after rst_n deasserts.

Verification
REQ-028 Write: START, 0x54, 0x12, 0x34, STOP -> ACK on all three bytes, op_a=0x12, op_b=0x34, single op_valid pulse after byte 2.
REQ-029 Wrong address: START, 0x56, 0x11 -> sda_oe never asserted, op_a/op_b/op_valid unchanged, busy 0 after address byte.
REQ-030 Read: result=0xA5, START, 0x55, master reads 8 bits then NACKs -> SDA bits 1010_0101, state IDLE after NACK.
REQ-031 Overflow: write 0x54, 0x01, 0x02, 0x99 -> byte 0x99 NACKed, op_a=0x01, op_b=0x02, only one op_valid.
REQ-032 Repeated START: write 0x54, 0x07, then START, 0x55, read -> op_a=0x07, no op_valid, read returns current result.
REQ-033 Reset mid-read with sda_oe=1: rst_n low -> sda_oe=0 and busy=0 without waiting for clk.
